// File: rtl/sdio_txframe.sv
// sdio_txframe: card-side SDIO DAT transmit framer, 1- or 4-bit SDR, per-lane start bit, CRC16 and stop bit
module sdio_txframe #(
    parameter int NCLK_PRE    = 2,
    parameter bit OPT_ERRSTOP = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ckstb,
    input  logic        i_en,
    input  logic        i_width,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic [3:0]  o_dat,
    output logic [3:0]  o_dat_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    typedef enum logic [2:0] {IDLE, PRE, DATA, CRC, STOP} state_t;
    state_t state;
    logic wide, need_word, last_q;
    logic [7:0] prectr;
    logic [5:0] ctr, ctr_nx;
    logic [31:0] sreg, word, src;
    logic [3:0] nib, crc_msb;
    logic [3:0][15:0] crc, crc_nx, crc_sh;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // at a word boundary the next word comes straight from the stream (or is repeated on underrun)
    assign src = need_word ? (s_valid ? s_data : word) : sreg;
    assign nib = wide ? src[31:28] : {3'b111, src[31]};
    assign ctr_nx = need_word ? 6'd1 : ctr + 6'd1;
    assign crc_msb = wide ? {crc[3][15], crc[2][15], crc[1][15], crc[0][15]} : {3'b111, crc[0][15]};
    assign s_ready = i_ckstb && i_en && need_word && ((state == PRE && prectr == 8'd0) || (state == DATA && !last_q));

    always_comb begin
        crc_nx = crc;
        crc_sh = crc;
        for (int l = 0; l < 4; l++) begin
            crc_sh[l] = {crc[l][14:0], 1'b0};
            if (wide || l == 0) crc_nx[l] = crc_step(crc[l], wide ? src[28 + l] : src[31]);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            wide      <= 1'b0;
            need_word <= 1'b0;
            last_q    <= 1'b0;
            prectr    <= 8'd0;
            ctr       <= 6'd0;
            sreg      <= 32'd0;
            word      <= 32'd0;
            crc       <= '0;
            o_dat     <= 4'hf;
            o_dat_oe  <= 4'h0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            if (!i_en) begin
                state     <= IDLE;
                need_word <= 1'b0;
                last_q    <= 1'b0;
                prectr    <= 8'd0;
                ctr       <= 6'd0;
                crc       <= '0;
                o_dat     <= 4'hf;
                o_dat_oe  <= 4'h0;
                o_busy    <= 1'b0;
            end else if (i_ckstb) begin
                case (state)
                    IDLE: if (s_valid && !o_done) begin
                        state     <= PRE;
                        wide      <= i_width;
                        prectr    <= 8'(NCLK_PRE);
                        need_word <= 1'b1;
                        o_dat     <= 4'hf;
                        o_dat_oe  <= i_width ? 4'hf : 4'h1;
                        o_busy    <= 1'b1;
                    end
                    PRE: if (prectr != 8'd0) begin
                        prectr <= prectr - 8'd1;
                    end else if (s_valid) begin
                        state     <= DATA;
                        sreg      <= s_data;
                        word      <= s_data;
                        last_q    <= s_last;
                        need_word <= 1'b0;
                        ctr       <= 6'd0;
                        o_dat     <= wide ? 4'h0 : 4'he;
                    end
                    DATA: if (need_word && last_q) begin
                        state     <= CRC;
                        o_dat     <= crc_msb;
                        crc       <= crc_sh;
                        ctr       <= 6'd1;
                        need_word <= 1'b0;
                    end else if (need_word && !s_valid && OPT_ERRSTOP) begin
                        state     <= IDLE;
                        need_word <= 1'b0;
                        last_q    <= 1'b0;
                        ctr       <= 6'd0;
                        crc       <= '0;
                        o_dat     <= 4'hf;
                        o_dat_oe  <= 4'h0;
                        o_busy    <= 1'b0;
                        o_err     <= 1'b1;
                    end else begin
                        o_dat     <= nib;
                        crc       <= crc_nx;
                        sreg      <= wide ? {src[27:0], 4'h0} : {src[30:0], 1'b0};
                        ctr       <= ctr_nx;
                        need_word <= ctr_nx == (wide ? 6'd8 : 6'd32);
                        if (need_word) begin
                            word   <= src;
                            last_q <= s_valid && s_last;
                        end
                    end
                    CRC: if (ctr == 6'd16) begin
                        state <= STOP;
                        o_dat <= 4'hf;
                    end else begin
                        o_dat <= crc_msb;
                        crc   <= crc_sh;
                        ctr   <= ctr + 6'd1;
                    end
                    STOP: begin
                        state    <= IDLE;
                        last_q   <= 1'b0;
                        ctr      <= 6'd0;
                        crc      <= '0;
                        o_dat_oe <= 4'h0;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
